// File: rtl/controller_seq.sv
// controller_seq: eight-phase instruction sequencer for the VeriRISC core.
// One instruction takes eight clocks. The strobes are decoded combinationally
// from the current phase, the opcode and the zero flag. A HLT instruction
// freezes the sequencer until the next reset.
//
// phase       | meaning
// ------------+-----------------------------------------------------------
// INST_ADDR 0 | PC drives the memory address
// INST_FETCH 1| read the instruction word
// INST_LOAD 2 | load the instruction register
// IDLE 3      | hold the fetch strobes while the IR settles
// OP_ADDR 4   | advance the PC; HLT is recognised here
// OP_FETCH 5  | read the operand for ALU-class instructions
// ALU_OP 6    | SKZ skip, JMP load, STO drives the data bus
// STORE 7     | accumulator load, JMP load, STO write
// halted      | sticky flag; phase frozen, only halt asserted

module controller_seq #(
  parameter int OPC_W   = 3,
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               wr,
  output logic               ld_ir,
  output logic               ld_ac,
  output logic               data_e,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  typedef enum logic [PHASE_W-1:0] {
    PH_INST_ADDR  = PHASE_W'(0),
    PH_INST_FETCH = PHASE_W'(1),
    PH_INST_LOAD  = PHASE_W'(2),
    PH_IDLE       = PHASE_W'(3),
    PH_OP_ADDR    = PHASE_W'(4),
    PH_OP_FETCH   = PHASE_W'(5),
    PH_ALU_OP     = PHASE_W'(6),
    PH_STORE      = PHASE_W'(7)
  } phase_e;

  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic alu_op;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  // Phase and halt registers; reset wins over everything, including halt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next phase: free-running 0..7 wrap; HLT at OP_ADDR parks the phase at 4.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == PH_OP_ADDR && is_hlt) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + PHASE_W'(1));
      end
    end
  end

  // Strobe decode; once halted every strobe except halt is held low.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        PH_OP_FETCH: begin
          rd = alu_op;
        end
        PH_ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_controller_seq.sv
// Bench for controller_seq: table of per-phase expected strobes, applied
// through a scoreboard queue, plus hand-written halt and reset sequences.
module tb_controller_seq;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, ld_ac, data_e, inc_pc, ld_pc, halt;
  logic [2:0] phase;

  controller_seq #(.OPC_W(3), .PHASE_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .data_e (data_e),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .halt   (halt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bit positions in {sel,rd,wr,ld_ir,ld_ac,data_e,inc_pc,ld_pc,halt}
  localparam logic [8:0] SEL  = 9'h100;
  localparam logic [8:0] RD   = 9'h080;
  localparam logic [8:0] WR   = 9'h040;
  localparam logic [8:0] LDIR = 9'h020;
  localparam logic [8:0] LDAC = 9'h010;
  localparam logic [8:0] DE   = 9'h008;
  localparam logic [8:0] INC  = 9'h004;
  localparam logic [8:0] LDPC = 9'h002;
  localparam logic [8:0] HLT  = 9'h001;
  localparam logic [8:0] NONE = 9'h000;

  typedef struct {
    logic [2:0] opc;
    logic       z;
    logic [2:0] ph;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    int         tag;
    logic [2:0] ph;
    logic [8:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tag_cnt  = 0;

  // One instruction: the four fetch phases and OP_ADDR are common, the
  // last three phases are given explicitly per opcode.
  task automatic add_instr(input logic [2:0] opc, input logic z,
                           input logic [8:0] e5, input logic [8:0] e6,
                           input logic [8:0] e7);
    logic [8:0] e [8];
    e[0] = SEL;
    e[1] = SEL | RD;
    e[2] = SEL | RD | LDIR;
    e[3] = SEL | RD | LDIR;
    e[4] = INC;
    e[5] = e5;
    e[6] = e6;
    e[7] = e7;
    for (int p = 0; p < 8; p++) begin
      vecs.push_back('{opc: opc, z: z, ph: 3'(p), exp: e[p]});
    end
  endtask

  // Called at posedge+1: drive inputs, queue the expectation, sample at the
  // falling edge, compare, then move on to the next posedge+1.
  task automatic step(input logic rst_v, input logic [2:0] opc, input logic z,
                      input logic [2:0] ph, input logic [8:0] exp);
    sb_t        s;
    logic [8:0] act;
    rst    = rst_v;
    opcode = opc;
    zero   = z;
    sb_q.push_back('{tag: tag_cnt, ph: ph, exp: exp});
    tag_cnt++;
    @(negedge clk);
    s   = sb_q.pop_front();
    act = {sel, rd, wr, ld_ir, ld_ac, data_e, inc_pc, ld_pc, halt};
    n_checks++;
    if (act !== s.exp || phase !== s.ph) begin
      n_fail++;
      $display("FAIL step%0d: phase=%0d strobes=%b, expected phase=%0d strobes=%b",
               s.tag, phase, act, s.ph, s.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Table: one instruction per entry group.
    add_instr(3'd5, 1'b0, RD,   RD,   RD | LDAC);      // LDA
    add_instr(3'd1, 1'b1, NONE, INC,  NONE);           // SKZ, zero=1
    add_instr(3'd1, 1'b0, NONE, NONE, NONE);           // SKZ, zero=0
    add_instr(3'd7, 1'b0, NONE, LDPC, LDPC);           // JMP
    add_instr(3'd7, 1'b1, NONE, LDPC, LDPC);           // JMP, zero ignored
    add_instr(3'd6, 1'b1, NONE, DE,   DE | WR);        // STO
    add_instr(3'd2, 1'b1, RD,   RD,   RD | LDAC);      // ADD
    add_instr(3'd3, 1'b0, RD,   RD,   RD | LDAC);      // AND
    add_instr(3'd4, 1'b1, RD,   RD,   RD | LDAC);      // XOR

    rst    = 1'b0;
    opcode = 3'd7;
    zero   = 1'b1;
    @(posedge clk);
    #1;
    // Reset held for two clocks: reset outputs visible throughout.
    step(1'b0, 3'd7, 1'b1, 3'd0, SEL);
    step(1'b1, 3'd7, 1'b1, 3'd0, SEL);
    // Now one clock past release sampling; phase 0 seen above came from the
    // second reset edge, so realign: hold reset one more edge, then release.
    step(1'b0, 3'd5, 1'b0, 3'd1, SEL | RD);
    rst = 1'b1;

    // Reset released at posedge+1 of a phase-0 cycle: table runs from here.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].opc, vecs[i].z, vecs[i].ph, vecs[i].exp);
    end

    // HLT: fetch, then halt entry at phase 4, then 20 frozen cycles.
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 3'd0, 1'b0, 3'(p), vecs[p].exp);
    end
    step(1'b1, 3'd0, 1'b0, 3'd4, INC | HLT);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'd4, HLT);
    end
    // Reset cycle while halted still shows halt; next cycle is clean phase 0.
    step(1'b0, 3'd2, 1'b1, 3'd4, HLT);
    step(1'b1, 3'd2, 1'b1, 3'd0, SEL);
    step(1'b1, 3'd2, 1'b1, 3'd1, SEL | RD);

    // Finish that ADD, then a JMP aborted by reset in phase 6.
    for (int p = 2; p < 8; p++) begin
      step(1'b1, 3'd2, 1'b1, 3'(p), vecs[48 + p].exp);
    end
    for (int p = 0; p < 6; p++) begin
      step(1'b1, 3'd7, 1'b0, 3'(p), vecs[24 + p].exp);
    end
    step(1'b0, 3'd7, 1'b0, 3'd6, LDPC);
    step(1'b1, 3'd7, 1'b0, 3'd0, SEL);
    step(1'b1, 3'd7, 1'b0, 3'd1, SEL | RD);

    // Second halt, cleared by a reset after a few frozen cycles.
    for (int p = 2; p < 4; p++) begin
      step(1'b1, 3'd0, 1'b1, 3'(p), vecs[p].exp);
    end
    step(1'b1, 3'd0, 1'b1, 3'd4, INC | HLT);
    step(1'b1, 3'd7, 1'b1, 3'd4, HLT);
    step(1'b1, 3'd1, 1'b1, 3'd4, HLT);
    step(1'b0, 3'd7, 1'b0, 3'd4, HLT);
    step(1'b1, 3'd7, 1'b0, 3'd0, SEL);
    step(1'b1, 3'd7, 1'b0, 3'd1, SEL | RD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
